// File: rtl/uart_rx_cmd_ctrl.sv
// rtl/uart_rx_cmd_ctrl.sv - UART command-frame parser sequencing register-file writes and reads
module uart_rx_cmd_ctrl #(
    parameter int         ADDR_W  = 4,
    parameter int         TIMEOUT = 1024,
    parameter logic [7:0] OP_WR   = 8'hAA,
    parameter logic [7:0] OP_RD   = 8'hBB
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [7:0]        RX_P_DATA,
    input  logic              RX_D_VLD,
    input  logic              RX_PAR_ERR,
    input  logic              RX_STP_ERR,
    output logic              RF_WrEn,
    output logic              RF_RdEn,
    output logic [ADDR_W-1:0] RF_Address,
    output logic [7:0]        RF_WrData,
    input  logic [7:0]        RF_RdData,
    input  logic              RF_RdData_VLD,
    output logic [7:0]        TX_P_DATA,
    output logic              TX_D_VLD,
    input  logic              TX_BUSY,
    output logic              cmd_err,
    output logic              busy
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        IDLE, WR_ADDR, WR_DATA, WR_EXEC, RD_ADDR, RD_REQ, RD_WAIT, TX_WAIT
    } state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       rd_q;

    logic bad, good, arrive, addr_ok, waiting, expired;
    logic err_nx, tx_go, addr_ld, data_ld, cap_ld;

    assign bad     = RX_PAR_ERR | RX_STP_ERR;
    assign good    = RX_D_VLD & ~bad;
    assign arrive  = RX_D_VLD | bad;
    assign addr_ok = ((RX_P_DATA >> ADDR_W) == 8'd0);
    assign waiting = (state == WR_ADDR) || (state == WR_DATA) ||
                     (state == RD_ADDR) || (state == RD_WAIT);
    assign expired = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));
    assign busy    = (state != IDLE);

    always_comb begin
        state_nx = state;
        err_nx   = 1'b0;
        tx_go    = 1'b0;
        addr_ld  = 1'b0;
        data_ld  = 1'b0;
        cap_ld   = 1'b0;
        case (state)
            IDLE: begin
                if (bad) begin
                    err_nx = 1'b1;
                end else if (RX_D_VLD) begin
                    if (RX_P_DATA == OP_WR)      state_nx = WR_ADDR;
                    else if (RX_P_DATA == OP_RD) state_nx = RD_ADDR;
                    else                         err_nx   = 1'b1;
                end
            end
            WR_ADDR, RD_ADDR: begin
                if (good && addr_ok) begin
                    addr_ld  = 1'b1;
                    state_nx = (state == WR_ADDR) ? WR_DATA : RD_REQ;
                end else if (arrive || expired) begin
                    err_nx   = 1'b1;
                    state_nx = IDLE;
                end
            end
            WR_DATA: begin
                if (good) begin
                    data_ld  = 1'b1;
                    state_nx = WR_EXEC;
                end else if (bad || expired) begin
                    err_nx   = 1'b1;
                    state_nx = IDLE;
                end
            end
            WR_EXEC: begin
                err_nx   = arrive;
                state_nx = IDLE;
            end
            RD_REQ: begin
                err_nx   = arrive;
                state_nx = RD_WAIT;
            end
            RD_WAIT: begin
                // read data wins over a coincident byte, which is dropped
                err_nx = arrive;
                if (RF_RdData_VLD) begin
                    cap_ld   = 1'b1;
                    state_nx = TX_WAIT;
                end else if (expired) begin
                    err_nx   = 1'b1;
                    state_nx = IDLE;
                end
            end
            TX_WAIT: begin
                err_nx = arrive;
                if (!TX_BUSY) begin
                    tx_go    = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            cnt        <= '0;
            rd_q       <= '0;
            RF_WrEn    <= 1'b0;
            RF_RdEn    <= 1'b0;
            RF_Address <= '0;
            RF_WrData  <= '0;
            TX_P_DATA  <= '0;
            TX_D_VLD   <= 1'b0;
            cmd_err    <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= (state_nx != state || !waiting) ? '0 : cnt + 1'b1;
            cmd_err  <= err_nx;
            RF_WrEn  <= (state_nx == WR_EXEC);
            RF_RdEn  <= (state_nx == RD_REQ);
            TX_D_VLD <= tx_go;
            if (addr_ld) RF_Address <= RX_P_DATA[ADDR_W-1:0];
            if (data_ld) RF_WrData  <= RX_P_DATA;
            if (cap_ld)  rd_q       <= RF_RdData;
            if (tx_go)   TX_P_DATA  <= rd_q;
        end
    end

endmodule

// File: tb/tb_uart_rx_cmd_ctrl.sv
// tb/tb_uart_rx_cmd_ctrl.sv - scoreboard bench for uart_rx_cmd_ctrl with directed frames
module tb_uart_rx_cmd_ctrl;

    localparam logic [3:0] K_WR = 4'b1000, K_RD = 4'b0100, K_TX = 4'b0010, K_ER = 4'b0001;

    typedef struct {
        logic [3:0] kind;
        int         cyc;
        logic [7:0] addr;
        logic [7:0] data;
    } ev_t;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] RX_P_DATA = '0;
    logic       RX_D_VLD = 1'b0, RX_PAR_ERR = 1'b0, RX_STP_ERR = 1'b0;
    logic       RF_WrEn, RF_RdEn;
    logic [3:0] RF_Address;
    logic [7:0] RF_WrData;
    logic [7:0] RF_RdData = '0;
    logic       RF_RdData_VLD = 1'b0;
    logic [7:0] TX_P_DATA;
    logic       TX_D_VLD;
    logic       TX_BUSY = 1'b0;
    logic       cmd_err, busy;

    int  cyc = 0;
    int  checks = 0;
    int  errors = 0;
    ev_t exp_q[$];

    uart_rx_cmd_ctrl #(.ADDR_W(4), .TIMEOUT(16), .OP_WR(8'hAA), .OP_RD(8'hBB)) dut (
        .CLK(CLK), .RST(RST),
        .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
        .RX_PAR_ERR(RX_PAR_ERR), .RX_STP_ERR(RX_STP_ERR),
        .RF_WrEn(RF_WrEn), .RF_RdEn(RF_RdEn),
        .RF_Address(RF_Address), .RF_WrData(RF_WrData),
        .RF_RdData(RF_RdData), .RF_RdData_VLD(RF_RdData_VLD),
        .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .TX_BUSY(TX_BUSY),
        .cmd_err(cmd_err), .busy(busy)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc = cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input logic [3:0] kind, input int c, input logic [7:0] a, input logic [7:0] d);
        ev_t e;
        e.kind = kind; e.cyc = c; e.addr = a; e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic send(input logic [7:0] b, input logic par, input logic stp);
        RX_P_DATA  = b;
        RX_D_VLD   = 1'b1;
        RX_PAR_ERR = par;
        RX_STP_ERR = stp;
        step();
        RX_D_VLD   = 1'b0;
        RX_PAR_ERR = 1'b0;
        RX_STP_ERR = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wren"}, int'(RF_WrEn), 0);
        check({tag, "_rden"}, int'(RF_RdEn), 0);
        check({tag, "_addr"}, int'(RF_Address), 0);
        check({tag, "_wdata"}, int'(RF_WrData), 0);
        check({tag, "_txdata"}, int'(TX_P_DATA), 0);
        check({tag, "_txvld"}, int'(TX_D_VLD), 0);
        check({tag, "_err"}, int'(cmd_err), 0);
        check({tag, "_busy"}, int'(busy), 0);
    endtask

    // monitor: every strobe the DUT raises must match the oldest expectation
    always @(negedge CLK) begin
        if (!RST && (RF_WrEn || RF_RdEn || TX_D_VLD || cmd_err)) begin
            automatic logic [3:0] obs = {RF_WrEn, RF_RdEn, TX_D_VLD, cmd_err};
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got kind %b expected none (cycle %0d)", obs, cyc);
            end else begin
                automatic ev_t e = exp_q.pop_front();
                check("pulse_kind", int'(obs), int'(e.kind));
                check("pulse_cycle", cyc, e.cyc);
                if (e.kind == K_WR) begin
                    check("wr_addr", int'(RF_Address), int'(e.addr));
                    check("wr_data", int'(RF_WrData), int'(e.data));
                end
                if (e.kind == K_RD) check("rd_addr", int'(RF_Address), int'(e.addr));
                if (e.kind == K_TX) check("tx_data", int'(TX_P_DATA), int'(e.data));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        step();
        check_all_zero("reset");
        step();
        RST = 1'b0;
        step();

        // write AA 05 3C
        send(8'hAA, 0, 0);
        send(8'h05, 0, 0);
        push(K_WR, cyc + 1, 8'h05, 8'h3C);
        send(8'h3C, 0, 0);
        step();
        check("busy_after_write", int'(busy), 0);

        // read BB 05, data two cycles after RdEn, TX busy for 10 cycles
        send(8'hBB, 0, 0);
        push(K_RD, cyc + 1, 8'h05, 8'h00);
        send(8'h05, 0, 0);
        step();
        step();
        RF_RdData = 8'h3C; RF_RdData_VLD = 1'b1; TX_BUSY = 1'b1;
        step();
        RF_RdData_VLD = 1'b0;
        check("busy_tx_wait", int'(busy), 1);
        repeat (9) step();
        TX_BUSY = 1'b0;
        push(K_TX, cyc + 1, 8'h00, 8'h3C);
        step();
        step();

        // parity error mid-frame, then a good write, bad opcode, out-of-range address
        send(8'hAA, 0, 0);
        push(K_ER, cyc + 1, 8'h00, 8'h00);
        send(8'h05, 1, 0);
        step();
        send(8'hAA, 0, 0);
        send(8'h02, 0, 0);
        push(K_WR, cyc + 1, 8'h02, 8'h7E);
        send(8'h7E, 0, 0);
        step();
        push(K_ER, cyc + 1, 8'h00, 8'h00);
        send(8'h11, 0, 0);
        send(8'hAA, 0, 0);
        push(K_ER, cyc + 1, 8'h00, 8'h00);
        send(8'h15, 0, 0);
        step();
        check("busy_after_errs", int'(busy), 0);
        check("addr_kept", int'(RF_Address), 2);

        // timeout after 16 silent cycles in WR_ADDR
        send(8'hAA, 0, 0);
        k = cyc;
        push(K_ER, k + 16, 8'h00, 8'h00);
        repeat (15) step();
        check("busy_before_timeout", int'(busy), 1);
        step();
        check("busy_after_timeout", int'(busy), 0);
        push(K_ER, cyc + 1, 8'h00, 8'h00);
        send(8'h05, 0, 0);
        step();

        // asynchronous reset while in WR_DATA
        send(8'hAA, 0, 0);
        send(8'h05, 0, 0);
        #2 RST = 1'b1;
        #1 check_all_zero("midreset");
        step();
        RST = 1'b0;
        step();
        push(K_ER, cyc + 1, 8'h00, 8'h00);
        send(8'h3C, 0, 0);
        step();
        check("no_write_after_reset", int'(RF_WrData), 0);

        // stray byte during RD_WAIT is dropped, read completes
        send(8'hBB, 0, 0);
        push(K_RD, cyc + 1, 8'h06, 8'h00);
        send(8'h06, 0, 0);
        step();
        push(K_ER, cyc + 1, 8'h00, 8'h00);
        send(8'h55, 0, 0);
        check("busy_rd_wait", int'(busy), 1);
        RF_RdData = 8'hA5; RF_RdData_VLD = 1'b1;
        push(K_TX, cyc + 2, 8'h00, 8'hA5);
        step();
        RF_RdData_VLD = 1'b0;
        repeat (3) step();
        check("tx_data_hold", int'(TX_P_DATA), 8'hA5);

        // byte and read data in the same RD_WAIT cycle
        send(8'hBB, 0, 0);
        push(K_RD, cyc + 1, 8'h07, 8'h00);
        send(8'h07, 0, 0);
        step();
        RF_RdData = 8'h5A; RF_RdData_VLD = 1'b1;
        push(K_ER, cyc + 1, 8'h00, 8'h00);
        push(K_TX, cyc + 2, 8'h00, 8'h5A);
        send(8'h99, 0, 0);
        RF_RdData_VLD = 1'b0;
        repeat (4) step();
        check("busy_end", int'(busy), 0);

        check("pending_expectations", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_cmd_ctrl.md
Name: uart_rx_cmd_ctrl

Overview:
Command-frame controller sitting behind the UART receiver top. It consumes received bytes (P_DATA/data_valid/par_error/stop_error), parses write/read command frames, and sequences register-file accesses. For reads it returns the data through a UART transmitter handshake. A per-state inter-byte timeout aborts stalled frames.

Parameters:
ADDR_W, 4, register-file address width (1..8)
TIMEOUT, 1024, idle cycles allowed in a waiting state before abort; 0 disables the timeout
OP_WR, 8'hAA, write opcode (frame: OP_WR, addr, data)
OP_RD, 8'hBB, read opcode (frame: OP_RD, addr)

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous reset, active high
RX_P_DATA  in  8  received byte
RX_D_VLD  in  1  one-cycle pulse, RX_P_DATA valid
RX_PAR_ERR  in  1  parity error on the current byte
RX_STP_ERR  in  1  stop-bit error on the current byte
RF_WrEn  out  1  register-file write strobe, one cycle
RF_RdEn  out  1  register-file read strobe, one cycle
RF_Address  out  ADDR_W  register-file address
RF_WrData  out  8  register-file write data
RF_RdData  in  8  register-file read data
RF_RdData_VLD  in  1  read data valid, one-cycle pulse
TX_P_DATA  out  8  byte to transmit
TX_D_VLD  out  1  one-cycle transmit request
TX_BUSY  in  1  transmitter busy
cmd_err  out  1  one-cycle pulse on any frame abort or dropped byte
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset: async, active high. All outputs 0, state IDLE, timeout counter 0, internal address/data registers 0.
- Good byte: RX_D_VLD=1 with RX_PAR_ERR=0 and RX_STP_ERR=0. Bad byte: RX_PAR_ERR or RX_STP_ERR high in any cycle.
- States: IDLE, WR_ADDR, WR_DATA, WR_EXEC, RD_ADDR, RD_REQ, RD_WAIT, TX_WAIT.
- IDLE:
  - good byte == OP_WR -> WR_ADDR.
  - good byte == OP_RD -> RD_ADDR.
  - any other good byte -> cmd_err, stay IDLE.
  - bad byte -> cmd_err, stay IDLE.
- WR_ADDR / RD_ADDR, on a good byte:
  - bits [7:ADDR_W] nonzero -> cmd_err, IDLE.
  - otherwise latch the low ADDR_W bits into RF_Address -> WR_DATA / RD_REQ.
- WR_DATA: good byte -> latch into RF_WrData -> WR_EXEC.
- WR_EXEC: RF_WrEn=1 for exactly this cycle -> IDLE. RF_WrEn is high on the cycle after the data byte is accepted.
- RD_REQ: RF_RdEn=1 for exactly this cycle -> RD_WAIT.
- RD_WAIT: on RF_RdData_VLD, capture RF_RdData -> TX_WAIT.
- TX_WAIT:
  - TX_BUSY=0 -> drive TX_P_DATA = captured byte, TX_D_VLD=1 for one cycle -> IDLE.
  - TX_BUSY=1 -> hold.
  - TX_P_DATA holds its value until the next read.
- Bad byte in WR_ADDR, WR_DATA or RD_ADDR: cmd_err, abort to IDLE, no RF strobe.
- Any byte arriving in WR_EXEC, RD_REQ, RD_WAIT or TX_WAIT: dropped, cmd_err pulse, state unaffected.
- Timeout counter:
  - Cleared on every state change; increments each cycle in WR_ADDR, WR_DATA, RD_ADDR and RD_WAIT.
  - When it reaches TIMEOUT-1 with no progress event that cycle: next edge -> IDLE with cmd_err.
  - A progress event on the same cycle wins over the timeout.
  - TIMEOUT=0: the counter never expires.
- cmd_err and all strobes are registered single-cycle pulses. Two error causes in one cycle give one pulse.
- RF_Address and RF_WrData are stable from latch until the next frame overwrites them.
- Simultaneous RX_D_VLD and RF_RdData_VLD in RD_WAIT: the read data is captured and the byte is dropped with cmd_err.

Test Plan:
- Write: AA, 05, 3C (ADDR_W=4) -> one-cycle RF_WrEn one cycle after the 3C byte; RF_Address=5, RF_WrData=3C; cmd_err never asserted; busy low after.
- Read: BB, 05; RF_RdData_VLD with 3C two cycles after RF_RdEn; TX_BUSY high 10 more cycles -> TX_D_VLD pulses with TX_P_DATA=3C on the cycle after TX_BUSY falls.
- Errors:
  - AA, then 05 with RX_PAR_ERR=1 -> cmd_err pulse, IDLE, no RF_WrEn.
  - Next AA, 02, 7E -> normal write to address 2.
  - Opcode 0x11 -> cmd_err.
  - AA, 15 (upper bit set, ADDR_W=4) -> cmd_err, no write.
- Timeout (TIMEOUT=16): AA, then silence 16 cycles -> cmd_err at cycle 16, IDLE.
  - Late 05 -> treated as an opcode -> cmd_err.
- Reset mid-frame: assert RST during WR_DATA -> all outputs 0 immediately.
  - After release, 3C -> cmd_err, no write.
- Byte during RD_WAIT: the byte is dropped with cmd_err, and the read still completes with correct TX data.
